mix_columns: RTL and testbench
==============================

// Module: mix_columns
// PURPOSE
//   AES-128 MixColumns stage; sits directly downstream of the row-shift stage.
//   Consumes shift_mat when finish_shift is high and produces mix_mat for AddRoundKey.
//   Columns are processed serially, COLS_PER_CYCLE per clock, under a small FSM.
//   last_round bypasses the mix (AES round 10) so the round loop is uniform.
// PARAMETERS
//   COLS_PER_CYCLE  1  columns mixed per clock; legal values 1, 2, 4 (latency = 4/COLS_PER_CYCLE)
// PORTS
//   clk           in   1    rising-edge clock
//   rst           in   1    asynchronous, active-high reset
//   finish_shift  in   1    level: shift_mat valid; held high until finish_mix seen
//   last_round    in   1    sampled with finish_shift; 1 = pass-through, no mix
//   shift_mat     in   128  state; byte(r,c) = [32r+8c+7 : 32r+8c], row r in [32r+31:32r]
//   finish_mix    out  1    level: mix_mat valid; held until finish_shift drops
//   mix_mat       out  128  mixed state, same byte layout as shift_mat
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, col=0, finish_mix=0, mix_mat=0, capture reg=0.
//     Mid-operation reset aborts; no partial result survives.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: on edge with finish_shift=1 (capture edge E0), latch shift_mat and last_round.
//     last_round=1: mix_mat<=shift_mat, finish_mix<=1 at E0, go DONE.
//     last_round=0: col<=0, go RUN.
//   RUN: each edge mixes columns col..col+COLS_PER_CYCLE-1 from the captured copy
//     and writes them into mix_mat; col += COLS_PER_CYCLE.
//     On the edge that writes column 3: finish_mix<=1, col<=0, go DONE.
//     finish_mix rises at E0+4/COLS_PER_CYCLE (4, 2 or 1 cycles later).
//     finish_shift dropping during RUN is ignored; the operation completes.
//   DONE: mix_mat and finish_mix held stable. When finish_shift=0: finish_mix<=0, go IDLE.
//     finish_shift still 1 -> stay DONE; no re-capture of the same data.
//   mix_mat is not valid while finish_mix=0. It may hold partial columns during RUN.
//   Column math, GF(2^8), with a0..a3 = rows 0..3 of one column:
//     xt(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00); 2a = xt(a); 3a = xt(a)^a
//     s0=2a0^3a1^a2^a3  s1=a0^2a1^3a2^a3  s2=a0^a1^2a2^3a3  s3=3a0^a1^a2^2a3
//   Pure XOR logic, 8-bit throughout, no carries. shift_mat is read only at E0;
//     upstream may change it afterwards.
//   Min turnaround: the next capture occurs at the first edge in IDLE with finish_shift=1.
// TESTING
//   1 Reset: assert rst mid-RUN -> finish_mix=0 and mix_mat=0 immediately (async);
//     after release, state is IDLE.
//   2 FIPS-197 vector, last_round=0: shift_mat=128'h4c015c45_31012253_26010a13_2d01f2db
//     -> mix_mat=128'hf8019dbc_bd0158a1_7e01dc4d_4d019f8e; finish_mix rises 4 clocks after E0 (CPC=1).
//   3 Latency sweep: repeat test 2 with COLS_PER_CYCLE=2 and 4 -> same mix_mat;
//     finish_mix rises at E0+2 and E0+1.
//   4 Bypass: last_round=1, same shift_mat -> mix_mat equals shift_mat and finish_mix=1 at E0.
//   5 Handshake: hold finish_shift=1 for 10 cycles past finish_mix -> single capture, outputs stable;
//     drop finish_shift -> finish_mix=0 next edge; re-raise it with
//     128'hd5d4d4d4_... column (d4,d4,d4,d5) -> column (d5,d5,d7,d6).
//   6 Input churn: change shift_mat every cycle during RUN -> result matches the value captured at E0.

Source files
------------

// File: rtl/mix_columns.sv
// AES-128 MixColumns stage: captures the shifted state, mixes COLS_PER_CYCLE
// columns per clock and presents the result under a level handshake.
`timescale 1ns/1ps

module mix_columns #(
    parameter int COLS_PER_CYCLE = 1    // legal values: 1, 2, 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         finish_shift,
    input  logic         last_round,
    input  logic [127:0] shift_mat,
    output logic         finish_mix,
    output logic [127:0] mix_mat
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic [1:0]   col, col_nxt;
    logic [2:0]   col_end;
    logic [127:0] cap, cap_nxt;
    logic [127:0] mix_nxt;
    logic         finish_nxt;

    // One past the last column written this cycle; reaching 4 means the state is complete.
    assign col_end = {1'b0, col} + 3'(COLS_PER_CYCLE);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] m, input int c);
        logic [31:0] v;
        for (int r = 0; r < 4; r++) begin
            v[8*r +: 8] = m[32*r + 8*c +: 8];
        end
        return v;
    endfunction

    // Column is packed with row r in bits [8r+7:8r].
    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [31:0] s;
        a0 = a[7:0];
        a1 = a[15:8];
        a2 = a[23:16];
        a3 = a[31:24];
        s[7:0]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
        s[15:8]  = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
        s[23:16] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
        s[31:24] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= 2'd0;
            cap        <= '0;
            mix_mat    <= '0;
            finish_mix <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            cap        <= cap_nxt;
            mix_mat    <= mix_nxt;
            finish_mix <= finish_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        cap_nxt    = cap;
        mix_nxt    = mix_mat;
        finish_nxt = finish_mix;
        case (state)
            IDLE: begin
                if (finish_shift) begin
                    cap_nxt = shift_mat;
                    if (last_round) begin
                        mix_nxt    = shift_mat;
                        finish_nxt = 1'b1;
                        state_nxt  = DONE;
                    end else begin
                        col_nxt   = 2'd0;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                // Work only from the captured copy; upstream may already be changing shift_mat.
                for (int c = 0; c < 4; c++) begin
                    if (c >= int'(col) && c < int'(col_end)) begin
                        logic [31:0] m;
                        m = mix_col(get_col(cap, c));
                        for (int r = 0; r < 4; r++) begin
                            mix_nxt[32*r + 8*c +: 8] = m[8*r +: 8];
                        end
                    end
                end
                if (col_end == 3'd4) begin
                    finish_nxt = 1'b1;
                    col_nxt    = 2'd0;
                    state_nxt  = DONE;
                end else begin
                    col_nxt = col_end[1:0];
                end
            end
            DONE: begin
                if (!finish_shift) begin
                    finish_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mix_columns.sv
// Bench for mix_columns: three instances (1, 2 and 4 columns per clock) share
// the same stimulus; results are checked against a table and a scoreboard queue.
`timescale 1ns/1ps

module tb_mix_columns;

    logic         clk = 1'b0;
    logic         rst;
    logic         finish_shift;
    logic         last_round;
    logic [127:0] shift_mat;
    logic         fin1, fin2, fin4;
    logic [127:0] mat1, mat2, mat4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         lr;
        logic [127:0] din;
        logic [127:0] dout;
        bit           churn;
        int           hold;
    } vec_t;

    vec_t         vecs [5];
    logic [127:0] exp_q [$];

    localparam logic [127:0] FIPS_IN  = 128'h4c015c45_31012253_26010a13_2d01f2db;
    localparam logic [127:0] FIPS_OUT = 128'hf8019dbc_bd0158a1_7e01dc4d_4d019f8e;
    localparam logic [127:0] D4_IN    = 128'hd5d5d5d5_d4d4d4d4_d4d4d4d4_d4d4d4d4;
    localparam logic [127:0] D4_OUT   = 128'hd6d6d6d6_d7d7d7d7_d5d5d5d5_d5d5d5d5;
    localparam logic [127:0] MIX_IN   = 128'h5c45d5c6_2253d4c6_0a13d4c6_f2dbd4c6;
    localparam logic [127:0] MIX_OUT  = 128'h9dbcd6c6_58a1d7c6_dc4dd5c6_9f8ed5c6;

    always #5 clk = ~clk;

    mix_columns #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .finish_shift(finish_shift), .last_round(last_round),
        .shift_mat(shift_mat), .finish_mix(fin1), .mix_mat(mat1)
    );
    mix_columns #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .finish_shift(finish_shift), .last_round(last_round),
        .shift_mat(shift_mat), .finish_mix(fin2), .mix_mat(mat2)
    );
    mix_columns #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .finish_shift(finish_shift), .last_round(last_round),
        .shift_mat(shift_mat), .finish_mix(fin4), .mix_mat(mat4)
    );

    function automatic logic get_fin(input int i);
        case (i)
            0:       return fin1;
            1:       return fin2;
            default: return fin4;
        endcase
    endfunction

    function automatic logic [127:0] get_mat(input int i);
        case (i)
            0:       return mat1;
            1:       return mat2;
            default: return mat4;
        endcase
    endfunction

    function automatic int cpc(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_output(input string name, input int i,
                                input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cpc=%0d actual=%h required=%h", name, cpc(i), act, req);
        end
    endtask

    // One full handshake: capture, wait for the result, optionally hold, then release.
    task automatic apply_stimulus(input vec_t v);
        int lat [3];
        logic [127:0] req;
        @(negedge clk);
        finish_shift = 1'b1;
        last_round   = v.lr;
        shift_mat    = v.din;
        exp_q.push_back(v.dout);
        for (int i = 0; i < 3; i++) lat[i] = -1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (lat[i] < 0 && get_fin(i) === 1'b1) lat[i] = k;
            end
            if (v.churn) shift_mat = rand128();
        end
        req = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            check_output("latency", i, 128'(lat[i]), 128'(v.lr ? 0 : 4 / cpc(i)));
            check_output("mix_mat", i, get_mat(i), req);
        end
        for (int h = 0; h < v.hold; h++) begin
            shift_mat = rand128();
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                check_output("hold_finish", i, 128'(get_fin(i)), 128'd1);
                check_output("hold_mat", i, get_mat(i), req);
            end
        end
        @(negedge clk);
        finish_shift = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_output("release", i, 128'(get_fin(i)), 128'd0);
    endtask

    initial begin
        vecs[0] = '{lr: 1'b0, din: FIPS_IN, dout: FIPS_OUT, churn: 1'b0, hold: 0};
        vecs[1] = '{lr: 1'b1, din: FIPS_IN, dout: FIPS_IN,  churn: 1'b0, hold: 0};
        vecs[2] = '{lr: 1'b0, din: MIX_IN,  dout: MIX_OUT,  churn: 1'b1, hold: 0};
        vecs[3] = '{lr: 1'b0, din: FIPS_IN, dout: FIPS_OUT, churn: 1'b1, hold: 10};
        vecs[4] = '{lr: 1'b0, din: D4_IN,   dout: D4_OUT,   churn: 1'b0, hold: 0};

        rst          = 1'b1;
        finish_shift = 1'b0;
        last_round   = 1'b0;
        shift_mat    = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output("reset_finish", i, 128'(get_fin(i)), 128'd0);
            check_output("reset_mat", i, get_mat(i), 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] table vectors");
        for (int n = 0; n < 5; n++) apply_stimulus(vecs[n]);

        // Asynchronous reset in the middle of a mix must clear outputs without a clock edge.
        $display("[TB] mid-run reset");
        @(negedge clk);
        finish_shift = 1'b1;
        last_round   = 1'b0;
        shift_mat    = FIPS_IN;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output("async_finish", i, 128'(get_fin(i)), 128'd0);
            check_output("async_mat", i, get_mat(i), 128'd0);
        end
        finish_shift = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_output("post_reset_idle", i, 128'(get_fin(i)), 128'd0);

        // Dropping finish_shift right after capture must not abort the mix.
        $display("[TB] early release");
        @(negedge clk);
        finish_shift = 1'b1;
        last_round   = 1'b0;
        shift_mat    = MIX_IN;
        @(posedge clk);
        @(negedge clk);
        finish_shift = 1'b0;
        shift_mat    = rand128();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (k == 4 / cpc(i)) begin
                    check_output("early_finish", i, 128'(get_fin(i)), 128'd1);
                    check_output("early_mat", i, get_mat(i), MIX_OUT);
                end
            end
        end
        repeat (2) @(posedge clk);

        // Normal operation after the reset proves the FSM came back to IDLE.
        apply_stimulus(vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
